// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Ordered, acknowledged reset release for STAGES downstream reset domains.
//   All rst_out bits assert together (asynchronously on rst, or on the edge
//   after a synchronous req). After a minimum hold they are released one
//   stage at a time; each stage's ack gates the release of the next, with an
//   optional gap and a per-stage timeout that forces progress.
//
// Ports
//   clk          sequencer clock
//   rst          async active-high reset; asserts every rst_out with no clock
//   req          synchronous reset request (level, sampled each rising edge)
//   stage_ack    per-stage ready, already synchronous to clk; only the bit of
//                the stage currently being waited on is looked at
//   rst_out      active-high reset per downstream domain
//   busy         high while a sequence is in progress (always !done)
//   done         high in IDLE once every stage is released
//   timeout_err  sticky for the current sequence; some stage ack timed out
module reset_sequencer #(
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [STAGES-1:0] stage_ack,
  output logic [STAGES-1:0] rst_out,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  // One counter is shared by the hold, gap and ack-timeout phases, so it is
  // sized for the largest of the three terminal counts.
  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int KW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  // Terminal values: the N-th edge of a phase is the one that sees N-1.
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(STAGES - 1);

  typedef enum logic [1:0] {
    ASSERT   = 2'd0,
    WAIT_ACK = 2'd1,
    GAP      = 2'd2,
    IDLE     = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [KW-1:0]     k, k_n, k_inc;
  logic [CW-1:0]     cnt, cnt_n;
  logic [STAGES-1:0] rst_out_n;
  logic              done_n, terr_n;
  logic              stage_done, release_next;

  assign k_inc = k + KW'(1);

  // State and all outputs are registers; busy is registered as the
  // complement of the next done so the two can never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ASSERT;
      k           <= '0;
      cnt         <= '0;
      rst_out     <= '1;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      cnt         <= cnt_n;
      rst_out     <= rst_out_n;
      busy        <= ~done_n;
      done        <= done_n;
      timeout_err <= terr_n;
    end
  end

  always_comb begin
    state_n      = state;
    k_n          = k;
    cnt_n        = cnt;
    rst_out_n    = rst_out;
    done_n       = done;
    terr_n       = timeout_err;
    stage_done   = 1'b0;
    release_next = 1'b0;

    if (req) begin
      // A held request parks the block in ASSERT with the counter cleared,
      // so the hold window starts on the first edge that sees req low.
      state_n   = ASSERT;
      k_n       = '0;
      cnt_n     = '0;
      rst_out_n = '1;
      done_n    = 1'b0;
      terr_n    = 1'b0;
    end else begin
      case (state)
        ASSERT: begin
          if (cnt == HOLD_LAST) begin
            rst_out_n[0] = 1'b0;
            k_n          = '0;
            cnt_n        = '0;
            state_n      = WAIT_ACK;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end

        WAIT_ACK: begin
          // An ack that is already high on the first edge here completes the
          // stage immediately (one-cycle minimum dwell).
          if (stage_ack[k]) begin
            stage_done = 1'b1;
          end else if (cnt == ACK_LAST) begin
            stage_done = 1'b1;
            terr_n     = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end

          if (stage_done) begin
            cnt_n = '0;
            if (k == K_LAST) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else if (GAP_CYCLES == 0) begin
              // No gap: release the next stage on this same edge.
              release_next = 1'b1;
              k_n          = k_inc;
            end else begin
              state_n = GAP;
            end
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            release_next = 1'b1;
            k_n          = k_inc;
            cnt_n        = '0;
            state_n      = WAIT_ACK;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end

        IDLE: begin
          // Released stages stay released; ack drops are ignored here.
        end

        default: begin
          state_n   = ASSERT;
          k_n       = '0;
          cnt_n     = '0;
          rst_out_n = '1;
          done_n    = 1'b0;
        end
      endcase
    end

    // Clearing only the bit for stage k+1 keeps earlier releases intact.
    if (release_next) begin
      for (int i = 0; i < STAGES; i++) begin
        if (KW'(i) == k_inc) rst_out_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst, req;
  logic [2:0] ack, ack0;
  logic [2:0] rst_out, rst_out0;
  logic       busy, done, terr, busy0, done0, terr0;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    int         dut_id;
    logic [2:0] ro;
    logic       bsy;
    logic       dn;
    logic       te;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t asb[$];
  event async_ev;

  // Default build (gap of 8) and a zero-gap build sharing clk/rst/req.
  reset_sequencer #(.STAGES(3), .HOLD_CYCLES(16), .GAP_CYCLES(8), .ACK_TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .req(req), .stage_ack(ack),
    .rst_out(rst_out), .busy(busy), .done(done), .timeout_err(terr)
  );

  reset_sequencer #(.STAGES(3), .HOLD_CYCLES(16), .GAP_CYCLES(0), .ACK_TIMEOUT(1024)) dut0 (
    .clk(clk), .rst(rst), .req(req), .stage_ack(ack0),
    .rst_out(rst_out0), .busy(busy0), .done(done0), .timeout_err(terr0)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Edge count since the last rst release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic push(input int c, input int d, input logic [2:0] ro,
                      input logic b, input logic dn, input logic te, input string tag);
    exp_t e;
    e.cyc = c; e.dut_id = d; e.ro = ro; e.bsy = b; e.dn = dn; e.te = te; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic apush(input int d, input logic [2:0] ro, input logic b,
                       input logic dn, input logic te, input string tag);
    exp_t e;
    e.cyc = -1; e.dut_id = d; e.ro = ro; e.bsy = b; e.dn = dn; e.te = te; e.tag = tag;
    asb.push_back(e);
  endtask

  task automatic cmp(input exp_t e);
    logic [5:0] a, x;
    x = {e.ro, e.bsy, e.dn, e.te};
    a = (e.dut_id == 0) ? {rst_out, busy, done, terr} : {rst_out0, busy0, done0, terr0};
    n_vec++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d rst_out,busy,done,terr got %b required %b",
               e.tag, e.dut_id, cyc, a, x);
    end
  endtask

  // Clocked monitor: compare at the falling edge whenever a checkpoint is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc != cyc) begin
          n_vec++; n_bad++;
          $display("FAIL %s checkpoint cyc=%0d missed, now %0d", e.tag, e.cyc, cyc);
        end else begin
          cmp(e);
        end
      end
    end
  end

  // Asynchronous monitor: checks taken between clock edges.
  initial begin
    exp_t e;
    forever begin
      @(async_ev);
      while (asb.size() > 0) begin
        e = asb.pop_front();
        cmp(e);
      end
    end
  end

  // Wait until the falling edge after edge n, then step off it by 1.
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) begin
      n_vec++; n_bad++;
      $display("FAIL wait_cyc timeout got cyc=%0d required %0d", cyc, n);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; ack = 3'b111; ack0 = 3'b111;

    // Reset with no clock running.
    #2;
    apush(0, 3'b111, 1'b1, 1'b0, 1'b0, "reset_noclk");
    apush(1, 3'b111, 1'b1, 1'b0, 1'b0, "reset_noclk_g0");
    -> async_ev;
    #3;

    // Normal sequence, both builds.
    push(15, 0, 3'b111, 1, 0, 0, "hold_before_16");
    push(15, 1, 3'b111, 1, 0, 0, "g0_hold_before_16");
    push(16, 0, 3'b110, 1, 0, 0, "rel0_at_16");
    push(16, 1, 3'b110, 1, 0, 0, "g0_rel0_at_16");
    push(17, 1, 3'b100, 1, 0, 0, "g0_rel1_at_17");
    push(18, 1, 3'b000, 1, 0, 0, "g0_rel2_at_18");
    push(19, 1, 3'b000, 0, 1, 0, "g0_done_at_19");
    push(24, 0, 3'b110, 1, 0, 0, "gap_before_25");
    push(25, 0, 3'b100, 1, 0, 0, "rel1_at_25");
    push(33, 0, 3'b100, 1, 0, 0, "gap_before_34");
    push(34, 0, 3'b000, 1, 0, 0, "rel2_at_34");
    push(35, 0, 3'b000, 0, 1, 0, "done_at_35");
    #5;
    rst = 1'b0;
    clk_en = 1'b1;
    wait_cyc(40);

    // Stage 1 never acks: timeout after 1024 WAIT_ACK edges.
    rst = 1'b1;
    ack = 3'b101;
    #1;
    apush(0, 3'b111, 1'b1, 1'b0, 1'b0, "reset_from_idle");
    -> async_ev;
    push(25,   0, 3'b100, 1, 0, 0, "to_rel1_at_25");
    push(1048, 0, 3'b100, 1, 0, 0, "to_no_err_1048");
    push(1049, 0, 3'b100, 1, 0, 1, "to_err_1049");
    push(1056, 0, 3'b100, 1, 0, 1, "to_gap_1056");
    push(1057, 0, 3'b000, 1, 0, 1, "to_rel2_1057");
    push(1058, 0, 3'b000, 0, 1, 1, "to_done_1058");
    push(1070, 0, 3'b000, 0, 1, 1, "to_err_sticky_idle");
    // req held 5 cycles from IDLE clears the error; hold restarts after it.
    push(1073, 0, 3'b111, 1, 0, 0, "req_clears_err");
    push(1077, 0, 3'b111, 1, 0, 0, "req_held");
    push(1092, 0, 3'b111, 1, 0, 0, "req_hold_before");
    push(1093, 0, 3'b110, 1, 0, 0, "req_rel0_16th");
    // req pulse mid-GAP restarts the full sequence.
    push(1096, 0, 3'b110, 1, 0, 0, "mid_gap");
    push(1097, 0, 3'b111, 1, 0, 0, "req_mid_gap");
    push(1112, 0, 3'b111, 1, 0, 0, "rs_hold_before");
    push(1113, 0, 3'b110, 1, 0, 0, "rs_rel0");
    push(1122, 0, 3'b100, 1, 0, 0, "rs_rel1");
    push(1131, 0, 3'b000, 1, 0, 0, "rs_rel2");
    push(1140, 0, 3'b000, 1, 0, 0, "wait_stage2");
    @(negedge clk); #1;
    rst = 1'b0;

    wait_cyc(1072);
    req = 1'b1;
    wait_cyc(1077);
    req = 1'b0;
    wait_cyc(1093);
    ack = 3'b111;
    wait_cyc(1096);
    req = 1'b1;
    wait_cyc(1097);
    req = 1'b0;
    wait_cyc(1125);
    ack = 3'b011;
    wait_cyc(1141);

    // Async rst while waiting on stage 2, checked before the next edge.
    rst = 1'b1;
    #1;
    apush(0, 3'b111, 1'b1, 1'b0, 1'b0, "async_rst_mid_wait");
    -> async_ev;
    ack = 3'b111;
    push(15, 0, 3'b111, 1, 0, 0, "post_rst_hold");
    push(16, 0, 3'b110, 1, 0, 0, "post_rst_rel0");
    push(25, 0, 3'b100, 1, 0, 0, "post_rst_rel1");
    push(34, 0, 3'b000, 1, 0, 0, "post_rst_rel2");
    push(35, 0, 3'b000, 0, 1, 0, "post_rst_done");
    @(negedge clk); #1;
    rst = 1'b0;
    wait_cyc(40);

    if (sb.size() != 0 || asb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain got %0d pending checkpoints required 0", sb.size() + asb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
